// File: rtl/sync_fifo_stat_if.sv
// Stream handshake and status bundle for sync_fifo_stat.
// The master side is the producer/consumer pair; the slave side is the FIFO.
interface sync_fifo_stat_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             io_flush;
    logic             io_write_valid;
    logic             io_write_ready;
    logic [WIDTH-1:0] io_write_bits;
    logic             io_read_valid;
    logic             io_read_ready;
    logic [WIDTH-1:0] io_read_bits;
    logic [CW-1:0]    io_count;
    logic             io_almost_full;
    logic             io_almost_empty;
    logic [CW-1:0]    io_peak;

    modport master (
        output io_flush, io_write_valid, io_write_bits, io_read_ready,
        input  io_write_ready, io_read_valid, io_read_bits, io_count,
               io_almost_full, io_almost_empty, io_peak
    );

    modport slave (
        input  io_flush, io_write_valid, io_write_bits, io_read_ready,
        output io_write_ready, io_read_valid, io_read_bits, io_count,
               io_almost_full, io_almost_empty, io_peak
    );
endinterface

// File: rtl/sync_fifo_stat.sv
// Single-clock first-word-fall-through FIFO with occupancy count, watermark
// flags, synchronous flush and a peak-occupancy monitor.
module sync_fifo_stat #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    parameter int CW        = $clog2(DEPTH) + 1
) (
    input logic             io_clk,
    input logic             io_rst_n,
    sync_fifo_stat_if.slave io
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_stat: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_stat: AF_THRESH outside 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_stat: AE_THRESH outside 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    peak;
    logic [CW-1:0]    count_next;
    logic             wr_acc;
    logic             rd_acc;

    // Handshake readiness decodes registered count only, so no input-to-output path.
    assign io.io_write_ready  = (count != FULL_C);
    assign io.io_read_valid   = (count != '0);
    assign io.io_read_bits    = mem[rd_ptr[AW-1:0]];
    assign io.io_count        = count;
    assign io.io_peak         = peak;
    assign io.io_almost_full  = (count >= AF_C);
    assign io.io_almost_empty = (count <= AE_C);

    assign wr_acc = io.io_write_valid && io.io_write_ready;
    assign rd_acc = io.io_read_valid && io.io_read_ready;

    always_comb begin
        // NOTE: default assigned first so every path drives count_next; no latch.
        count_next = count;
        if (io.io_flush) begin
            count_next = '0;
        end else if (wr_acc && !rd_acc) begin
            count_next = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values regardless of statement order.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            peak   <= '0;
        end else if (io.io_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            peak   <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + CW'(1);
            count <= count_next;
            if (count_next > peak) peak <= count_next;
        end
    end

    // NOTE: storage has no reset; read_bits is only meaningful while read_valid.
    always_ff @(posedge io_clk) begin
        if (wr_acc && !io.io_flush) begin
            mem[wr_ptr[AW-1:0]] <= io.io_write_bits;
        end
    end

    // Pointer distance must always equal occupancy, i.e. read never overtakes write.
    a_count_bound: assert property (@(posedge io_clk) disable iff (!io_rst_n)
        count <= FULL_C)
        else $error("sync_fifo_stat: count exceeds DEPTH");

    a_ptr_order: assert property (@(posedge io_clk) disable iff (!io_rst_n)
        CW'(wr_ptr - rd_ptr) == count)
        else $error("sync_fifo_stat: read pointer passed write pointer");
endmodule
